// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD adder/subtractor.
//   bcd_state_t    : controller states (COMP only reachable with BCD_SIGNED_EN)
//   BCD_DIGIT_W    : bits per packed BCD digit
//   BCD_RADIX      : decimal radix
//   BCD_OP_ADD/SUB : encoding of the op input
//   digit_invalid  : true for a nibble that is not a legal BCD digit
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_COMP = 2'd2,
        ST_DONE = 2'd3
    } bcd_state_t;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam int unsigned BCD_RADIX   = 10;

    localparam logic BCD_OP_ADD = 1'b0;
    localparam logic BCD_OP_SUB = 1'b1;

    function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] dig);
        return (dig > 4'(BCD_RADIX - 1));
    endfunction

endpackage

// File: rtl/bcd_digit_alu.sv
// Combinational one-digit BCD add/subtract cell.
// Ports:
//   op   : 0 = x+y+cin, 1 = x-y-cin
//   cin  : incoming carry (add) or borrow (sub)
//   x, y : BCD digit operands
//   d    : BCD result digit
//   cout : outgoing carry (add) or borrow (sub)
// Arithmetic is done 5 bits wide so the >9 / less-than compares see the
// untruncated value.
module bcd_digit_alu
    import bcd_pkg::*;
(
    input  logic       op,
    input  logic       cin,
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [3:0] d,
    output logic       cout
);

    logic [4:0] w_x5;
    logic [4:0] w_sum;
    logic [4:0] w_rhs;

    always_comb begin
        w_x5  = {1'b0, x};
        w_sum = w_x5 + {1'b0, y} + {4'b0, cin};
        w_rhs = {1'b0, y} + {4'b0, cin};
        d     = '0;
        cout  = 1'b0;
        if (op == BCD_OP_ADD) begin
            if (w_sum > 5'(BCD_RADIX - 1)) begin
                d    = 4'(w_sum - 5'(BCD_RADIX));
                cout = 1'b1;
            end else begin
                d    = w_sum[3:0];
            end
        end else begin
            if (w_x5 < w_rhs) begin
                d    = 4'(w_x5 + 5'(BCD_RADIX) - w_rhs);
                cout = 1'b1;
            end else begin
                d    = 4'(w_x5 - w_rhs);
            end
        end
    end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial N-digit packed-BCD adder/subtractor, one digit per clock,
// least-significant digit first, with a start/busy/done handshake.
// Optional feature macro: BCD_SIGNED_EN -- a subtraction ending in a borrow
// is converted to sign/magnitude by an extra COMP pass (0 - result).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   start    : request, sampled only in IDLE
//   op       : 0 = add, 1 = subtract (latched with start)
//   a, b     : packed BCD operands, digit 0 in bits [3:0] (latched with start)
//   busy     : operation in progress
//   done     : one-cycle pulse when result is valid
//   result   : packed BCD result, held until the next accepted start
//   carry    : carry (add) / borrow (sub) out of the top digit
//   neg      : subtraction result is negative
//   err      : a latched operand digit was >9
module bcd_addsub_serial
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
)
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          op,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] result,
    output logic                          carry,
    output logic                          neg,
    output logic                          err
);

    localparam int unsigned W     = BCD_DIGIT_W * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    bcd_state_t        r_state;
    bcd_state_t        w_next;
    logic              r_op;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [IDX_W-1:0]  r_idx;
    logic              r_cin;
    logic [W-1:0]      r_result;
    logic              r_carry;
    logic              r_neg;
    logic              r_err;
    logic              r_done;

    logic              w_last;
    logic              w_err_in;
    logic [3:0]        w_xa;
    logic [3:0]        w_yb;
    logic              w_alu_op;
    logic [3:0]        w_x;
    logic [3:0]        w_y;
    logic [3:0]        w_d;
    logic              w_cout;

    assign w_last = (r_idx == LAST_IDX);

    // Operand digit selected by the running digit index
    always_comb begin
        w_xa = '0;
        w_yb = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_xa = r_a[i*BCD_DIGIT_W +: BCD_DIGIT_W];
                w_yb = r_b[i*BCD_DIGIT_W +: BCD_DIGIT_W];
            end
        end
    end

    always_comb begin
        w_err_in = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            w_err_in = w_err_in
                     | digit_invalid(a[i*BCD_DIGIT_W +: BCD_DIGIT_W])
                     | digit_invalid(b[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
        end
    end

`ifdef BCD_SIGNED_EN
    logic [3:0] w_rd;

    always_comb begin
        w_rd = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_rd = r_result[i*BCD_DIGIT_W +: BCD_DIGIT_W];
            end
        end
    end
`endif

    // The single digit cell is shared: COMP feeds it 0 - result[idx]
    always_comb begin
        w_alu_op = r_op;
        w_x      = w_xa;
        w_y      = w_yb;
`ifdef BCD_SIGNED_EN
        if (r_state == ST_COMP) begin
            w_alu_op = BCD_OP_SUB;
            w_x      = '0;
            w_y      = w_rd;
        end
`endif
    end

    bcd_digit_alu u_alu (
        .op   (w_alu_op),
        .cin  (r_cin),
        .x    (w_x),
        .y    (w_y),
        .d    (w_d),
        .cout (w_cout)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
`ifdef BCD_SIGNED_EN
                    if ((r_op == BCD_OP_SUB) && w_cout) begin
                        w_next = ST_COMP;
                    end else begin
                        w_next = ST_DONE;
                    end
`else
                    w_next = ST_DONE;
`endif
                end
            end
`ifdef BCD_SIGNED_EN
            ST_COMP: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Datapath registers; done is registered on leaving DONE so it is
    // high in the first IDLE cycle, where a new start is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= BCD_OP_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_cin    <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op     <= op;
                        r_a      <= a;
                        r_b      <= b;
                        r_idx    <= '0;
                        r_cin    <= 1'b0;
                        r_result <= '0;
                        r_carry  <= 1'b0;
                        r_neg    <= 1'b0;
                        r_err    <= w_err_in;
                    end
                end
                ST_RUN: begin
                    for (int unsigned i = 0; i < DIGITS; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            r_result[i*BCD_DIGIT_W +: BCD_DIGIT_W] <= w_d;
                        end
                    end
                    r_cin <= w_cout;
                    r_idx <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_carry <= w_cout;
                        r_idx   <= '0;
                        r_cin   <= 1'b0;
`ifndef BCD_SIGNED_EN
                        r_neg   <= (r_op == BCD_OP_SUB) && w_cout;
`endif
                    end
                end
`ifdef BCD_SIGNED_EN
                ST_COMP: begin
                    for (int unsigned i = 0; i < DIGITS; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            r_result[i*BCD_DIGIT_W +: BCD_DIGIT_W] <= w_d;
                        end
                    end
                    r_cin <= w_cout;
                    r_idx <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_neg <= 1'b1;
                        r_idx <= '0;
                        r_cin <= 1'b0;
                    end
                end
`endif
                ST_DONE: begin
                    r_done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign done   = r_done;
    assign result = r_result;
    assign carry  = r_carry;
    assign neg    = r_neg;
    assign err    = r_err;

endmodule

// File: doc/bcd_addsub_serial.md
# bcd_addsub_serial

Digit-serial, N-digit packed-BCD adder/subtractor with a start/busy/done handshake. It is the multi-digit successor to the single-digit decimal subtractor. It processes one BCD digit per clock, least-significant first, and chains carry/borrow between digits. Counter and timer datapaths use it wherever they need decimal differences or sums wider than one digit.

## Interface
- `DIGITS`, default 4: number of BCD digits per operand (≥1).
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request an operation. Sampled only in IDLE.
- `op` in 1: 0 = A+B, 1 = A−B. Latched with `start`.
- `a` in 4·DIGITS: operand A, packed BCD, digit 0 in bits [3:0]. Latched with `start`.
- `b` in 4·DIGITS: operand B, same format. Latched with `start`.
- `busy` out 1: high while an operation is in progress.
- `done` out 1: one-cycle pulse when the result is valid.
- `result` out 4·DIGITS: packed BCD result. Held until the next accepted `start`.
- `carry` out 1: add = decimal carry out of the top digit; sub = borrow out of the top digit.
- `neg` out 1: sub result is negative (see Configuration).
- `err` out 1: some latched operand digit was >9.

Clock is `clk` and reset is `rst`: one clock, asynchronous active-high reset.

## Operation
- States: IDLE, RUN, COMP (only with the macro), DONE.
- IDLE:
  - `start`=1 latches `a`, `b` and `op`.
  - Clears `result`, `carry`, `neg` and the digit index; sets cin=0.
  - Sets `err` = OR over all operand digits of (digit>9).
  - Moves to RUN.
- RUN:
  - Each cycle computes digit `idx` from `a[idx]`, `b[idx]` and cin.
  - Add: s=a+b+cin; if s>9 then digit=s−10 and cout=1, else digit=s and cout=0.
  - Sub: if a < b+cin then digit=a+10−b−cin and cout=1, else digit=a−b−cin and cout=0.
  - Internal arithmetic is 5 bits wide, so there is no truncation before the compare.
  - Writes the digit into `result[idx]`; cin ← cout; idx++.
  - After digit DIGITS−1: `carry` ← cout, then go to DONE (or to COMP, see Configuration).
- COMP:
  - Re-runs the digit chain as 0 − `result` with borrow and writes the digits back in place.
  - Sets `neg`=1, then goes to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Invalid digits (>9) are still processed with the formulas above; the output digits are unspecified, and `err` flags the operation.
- `start` while busy or in DONE is ignored.
- Reset mid-operation:
  - Immediate return to IDLE.
  - All outputs go to their reset values; the partial result is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `carry`=0, `neg`=0, `err`=0; state IDLE.
- `start` accepted at edge k: `busy`=1 from k.
- Digit i is written at edge k+1+i.
- No COMP: `done`=1 during the cycle after edge k+DIGITS+1. `busy` falls at that same edge.
- With COMP: latency increases by DIGITS cycles.
- Earliest next `start` is the edge at which `done` is high.
- `result`, `carry`, `neg` and `err` are stable from `done` until the next accepted `start`.

## Configuration
- `BCD_SIGNED_EN` defined:
  - A subtraction that ends with borrow=1 enters COMP.
  - `result` = |A−B| in BCD, `neg`=1, `carry`=1.
- `BCD_SIGNED_EN` undefined:
  - No COMP state.
  - Subtraction wraps modulo 10^DIGITS: `result` = A−B+10^DIGITS, `carry`=1.
  - `neg` mirrors `carry` for subtraction and is 0 for addition.

## Structure
- Package `bcd_pkg` holds:
  - the state enum (IDLE, RUN, COMP, DONE);
  - `BCD_DIGIT_W`=4;
  - `BCD_RADIX`=10;
  - the op encoding constants `BCD_OP_ADD` and `BCD_OP_SUB`.
- Sub-module `bcd_digit_alu` is a combinational one-digit unit:
  - inputs `op`, `cin`, `x[3:0]`, `y[3:0]`;
  - outputs `d[3:0]`, `cout`.
- One `bcd_digit_alu` instance is shared by RUN and COMP. In COMP its inputs are x=0, y=`result[idx]`, op=SUB.

## Test plan
- DIGITS=4, add 1234+8766 → `result`=0000, `carry`=1, `neg`=0, `done` 5 cycles after the start edge.
- Sub 5000−1234 → `result`=3766, `carry`=0, `neg`=0.
- Sub 1234−5000:
  - without macro → 6234, `carry`=1, `neg`=1, latency 5;
  - with `BCD_SIGNED_EN` → 3766, `neg`=1, latency 9.
- Borrow chain: sub 1000−0001 → 0999. `start` pulsed again during `busy` → ignored, and `result` is unchanged.
- Operand `a`=00A0, add 0 → `err`=1 at `done`. The next operation with valid digits clears `err`.
- Assert `rst` on the 2nd RUN cycle → all outputs 0 in the same cycle and state IDLE. A new 0009+0001 then gives 0010 with `carry`=0.
